// File: rtl/fwd_sel_unit.sv
// fwd_sel_unit: forwarding / load-use hazard controller for a 5-stage pipeline.
// Tracks destination tags of in-flight instructions (EX, MEM, WB) and produces
// registered operand-mux selects for the instruction entering EX, plus a
// combinational load-use stall.
//
// Select encoding: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result,
//                  11 WB-retired holding register.
//
// Optional feature macro: STALL_CNT_EN (saturating stall counter on STALL_COUNT;
// when undefined the port is tied to zero and no counter flops exist).
module fwd_sel_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_WE,
  input  logic              ID_LOAD,
  input  logic              FLUSH,
  output logic              STALL,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic [CNT_W-1:0]  STALL_COUNT
);

  // EX keeps the full record; MEM and WB only need "writes" and the address,
  // since the load flag only matters while the producer sits in EX.
  logic              ex_v;
  logic              ex_we;
  logic              ex_ld;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_wr;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_wr;
  logic [REG_AW-1:0] wb_rd;

  logic              ex_wr;
  logic              advance;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;

  // Nearest producer wins; register 0 never forwards.
  function automatic logic [1:0] pick_sel(
    input logic [REG_AW-1:0] r,
    input logic              e_wr,
    input logic [REG_AW-1:0] e_rd,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_wr,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] s;
    s = 2'b00;
    if (r != '0) begin
      if (e_wr && (e_rd == r))      s = 2'b01;
      else if (m_wr && (m_rd == r)) s = 2'b10;
      else if (w_wr && (w_rd == r)) s = 2'b11;
    end
    return s;
  endfunction

  assign ex_wr = ex_v & ex_we;

  // Load-use hazard against the instruction currently in EX; FLUSH overrides.
  always_comb begin
    STALL = ID_VALID & ~FLUSH & ex_v & ex_we & ex_ld & (ex_rd != '0) &
            ((ex_rd == ID_RS) | (ex_rd == ID_RT));
  end

  // Select computation against the pre-edge tags.
  always_comb begin
    advance = ID_VALID & ~FLUSH & ~STALL;
    sel_a   = pick_sel(ID_RS, ex_wr, ex_rd, mem_wr, mem_rd, wb_wr, wb_rd);
    sel_b   = pick_sel(ID_RT, ex_wr, ex_rd, mem_wr, mem_rd, wb_wr, wb_rd);
  end

  // Tag pipeline shift and registered selects; bubble on flush/stall/idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_v   <= 1'b0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_rd  <= '0;
      mem_wr <= 1'b0;
      mem_rd <= '0;
      wb_wr  <= 1'b0;
      wb_rd  <= '0;
      FWD_A  <= 2'b00;
      FWD_B  <= 2'b00;
    end else begin
      wb_wr  <= mem_wr;
      wb_rd  <= mem_rd;
      mem_wr <= ex_wr;
      mem_rd <= ex_rd;
      if (advance) begin
        ex_v  <= 1'b1;
        ex_we <= ID_WE;
        ex_ld <= ID_LOAD;
        ex_rd <= ID_RD;
        FWD_A <= sel_a;
        FWD_B <= sel_b;
      end else begin
        ex_v  <= 1'b0;
        ex_we <= 1'b0;
        ex_ld <= 1'b0;
        ex_rd <= '0;
        FWD_A <= 2'b00;
        FWD_B <= 2'b00;
      end
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of stall cycles since reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      STALL_COUNT <= '0;
    else if (STALL && (STALL_COUNT != {CNT_W{1'b1}}))
      STALL_COUNT <= STALL_COUNT + 1'b1;
  end
`else
  // Counter disabled: port kept for a stable interface, driven to zero.
  assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed self-checking bench for fwd_sel_unit.
module tb_fwd_sel_unit;

  logic        CLK;
  logic        RST_N;
  logic        ID_VALID;
  logic [4:0]  ID_RS;
  logic [4:0]  ID_RT;
  logic [4:0]  ID_RD;
  logic        ID_WE;
  logic        ID_LOAD;
  logic        FLUSH;
  logic        STALL;
  logic [1:0]  FWD_A;
  logic [1:0]  FWD_B;
  logic [15:0] STALL_COUNT;

  int total = 0;
  int bad   = 0;

  fwd_sel_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .ID_VALID(ID_VALID), .ID_RS(ID_RS),
    .ID_RT(ID_RT), .ID_RD(ID_RD), .ID_WE(ID_WE), .ID_LOAD(ID_LOAD),
    .FLUSH(FLUSH), .STALL(STALL), .FWD_A(FWD_A), .FWD_B(FWD_B),
    .STALL_COUNT(STALL_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a decode instruction and let it settle (no clock edge).
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic fl);
    ID_VALID = v; ID_RS = rs; ID_RT = rt; ID_RD = rd;
    ID_WE = we; ID_LOAD = ld; FLUSH = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #10;
    chk("reset_fwd_a", 16'(FWD_A), 16'h0);
    chk("reset_fwd_b", 16'(FWD_B), 16'h0);
    chk("reset_stall", 16'(STALL), 16'h0);
    chk("reset_count", STALL_COUNT, 16'h0);
    #1 RST_N = 1'b1;

    // Back-to-back ALU dependency
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b2b_stall", 16'(STALL), 16'h0);
    tick();
    chk("b2b_fwd_a", 16'(FWD_A), 16'h1);
    chk("b2b_fwd_b", 16'(FWD_B), 16'h0);
    idle(4);

    // Distance 2
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("dist2_fwd_a", 16'(FWD_A), 16'h2);
    idle(4);

    // Distance 3
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("dist3_fwd_b", 16'(FWD_B), 16'h3);
    chk("dist3_fwd_a", 16'(FWD_A), 16'h0);
    idle(4);

    // Load-use: one stall cycle, bubble, then MEM forward
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_on", 16'(STALL), 16'h1);
    tick();
    chk("lu_bubble_a", 16'(FWD_A), 16'h0);
    drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_stall_off", 16'(STALL), 16'h0);
    tick();
    chk("lu_fwd_a", 16'(FWD_A), 16'h2);
`ifdef STALL_CNT_EN
    chk("lu_count", STALL_COUNT, 16'h1);
`else
    chk("lu_count", STALL_COUNT, 16'h0);
`endif
    idle(4);

    // Nearest producer priority and source 0
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("prio_fwd_a", 16'(FWD_A), 16'h1);
    chk("prio_fwd_b", 16'(FWD_B), 16'h0);
    idle(4);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("r0_fwd_a", 16'(FWD_A), 16'h0);
    chk("r0_fwd_b", 16'(FWD_B), 16'h0);
    idle(4);

    // FLUSH beats a load-use hazard
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", 16'(STALL), 16'h0);
    tick();
    chk("fl_bubble_a", 16'(FWD_A), 16'h0);
    drive(1'b1, 5'd10, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("fl_next_stall", 16'(STALL), 16'h0);
    tick();
    chk("fl_flushed_a", 16'(FWD_A), 16'h0);
    chk("fl_load_b", 16'(FWD_B), 16'h2);
    idle(4);

    // Async reset mid-stream
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0); tick();
    chk("ar_live_a", 16'(FWD_A), 16'h1);
    drive(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ar_live_stall", 16'(STALL), 16'h1);
    #1 RST_N = 1'b0;
    #1;
    chk("ar_fwd_a", 16'(FWD_A), 16'h0);
    chk("ar_fwd_b", 16'(FWD_B), 16'h0);
    chk("ar_stall", 16'(STALL), 16'h0);
    chk("ar_count", STALL_COUNT, 16'h0);
    #2 RST_N = 1'b1;
    drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("ar_after_a", 16'(FWD_A), 16'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_sel_unit.md
Name: fwd_sel_unit

Overview:
- Forwarding/hazard controller for the 5-stage pipeline.
- Tracks destination-register tags of in-flight instructions in an internal EX/MEM/WB tag pipeline.
- Produces registered 2-bit selects that drive the two 4:1 ALU-operand muxes, plus a load-use STALL.
- Sits between decode (consumes ID operand fields) and the EX-stage operand muxes (feeds their SEL inputs).

Parameters:
- REG_AW, 5, register-address width (32 architectural registers; register 0 hard-wired zero).
- CNT_W, 16, width of optional stall counter.

Ports:
- CLK  input  1  pipeline clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- ID_VALID  input  1  decode stage holds a real instruction
- ID_RS  input  REG_AW  source A register of decode instruction
- ID_RT  input  REG_AW  source B register of decode instruction
- ID_RD  input  REG_AW  destination register of decode instruction
- ID_WE  input  1  decode instruction writes ID_RD
- ID_LOAD  input  1  decode instruction is a load
- FLUSH  input  1  squash decode instruction (branch taken)
- STALL  output  1  hold PC and IF/ID, insert bubble into EX (combinational)
- FWD_A  output  2  operand-A mux select, valid while the instruction is in EX
- FWD_B  output  2  operand-B mux select, valid while the instruction is in EX
- STALL_COUNT  output  CNT_W  saturating stall count (only with STALL_CNT_EN)

Behaviour:
- Select encoding: 00 register file; 01 EX/MEM ALU result; 10 MEM/WB result; 11 WB-retired holding register (value written one cycle earlier).
- Tag record per stage: {v, we, ld, rd}. A tag "writes r" iff v & we & rd==r & r!=0.
- Reset (RST_N low, async): all tags v=0; FWD_A=FWD_B=00; STALL=0; STALL_COUNT=0.
- STALL = ID_VALID & !FLUSH & EX.v & EX.we & EX.ld & EX.rd!=0 & (EX.rd==ID_RS | EX.rd==ID_RT). Combinational, depends on current tags and ID inputs only.
- Every rising edge (RST_N high):
  - WB_RET <= WB; WB <= MEM; MEM <= EX.
  - If FLUSH or STALL or !ID_VALID: EX <= bubble (v=0) and FWD_A/FWD_B <= 00.
  - Else: EX <= {1, ID_WE, ID_LOAD, ID_RD}; FWD_A computed from ID_RS, FWD_B from ID_RT.
- Select computation for source r, evaluated against pre-edge tags, nearest producer first:
  - EX writes r -> 01.
  - Else MEM writes r -> 10.
  - Else WB writes r -> 11.
  - Else 00.
- The 11 case covers the regfile write/read collision at the WB stage.
- A load matched in EX never yields 01: STALL blocks it. After one bubble, the load sits in MEM and the re-presented instruction gets 10.
- Source 0 always selects 00, even when a tag has rd=0.
- FLUSH and a load-use hazard in the same cycle: FLUSH wins, STALL=0, bubble inserted.
- STALL lasts exactly one cycle per hazard; a dependent instruction never stalls twice for the same load.
- RST_N asserted mid-stream: all in-flight tags are discarded immediately; the first instruction after release sees no forwarding.
- Latency: selects appear one cycle after the instruction is presented on ID_* (the cycle it occupies EX).

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: STALL_COUNT increments on every edge where STALL=1, saturates at all-ones, and clears on reset.
- Undefined: the STALL_COUNT port still exists, is tied to 0, and has no counter flops.

Test Plan:
- Back-to-back ALU dependency: I1 rd=3 we=1, then I2 rs=3 rt=4 -> cycle I2 in EX: FWD_A=01, FWD_B=00, STALL never high.
- Distance 2 and 3: I1 rd=5; filler rd=7; I3 rs=5 -> FWD_A=10. With two fillers, I4 rt=5 -> FWD_B=11.
- Load-use: load rd=8, then I2 rs=8 -> STALL=1 for exactly one cycle, EX bubble with FWD=00, then I2 in EX with FWD_A=10. STALL_COUNT=1 when STALL_CNT_EN is defined.
- Priority and zero register: I1 rd=6, I2 rd=6, I3 rs=6 rt=0 -> FWD_A=01 (nearest producer), FWD_B=00. Separately, a writer with rd=0 followed by rs=0 -> 00.
- FLUSH against hazard: load rd=9, then FLUSH=1 with ID_RS=9 -> STALL=0, bubble, and the next valid instruction's selects ignore the flushed tag.
- Async reset mid-stream: assert RST_N low between edges with tags live -> FWD_A/FWD_B=00 and STALL=0 immediately. After release, I rs=3 -> FWD_A=00.
